// File: rtl/bask_demod_if.sv
// Sample stream in, bit/word decisions out, for the BASK receiver.
interface bask_demod_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       start;
  logic       busy;
  logic       bit_out;
  logic       bit_valid;
  logic [7:0] data_out;
  logic       data_valid;

  modport master (
    output sample_in, sample_valid, start,
    input  busy, bit_out, bit_valid, data_out, data_valid
  );

  modport slave (
    input  sample_in, sample_valid, start,
    output busy, bit_out, bit_valid, data_out, data_valid
  );
endinterface

// File: rtl/bask_demod.sv
// Binary ASK receiver: integrates each bit period, slices against THRESHOLD, assembles MSB-first bytes.
// Bit/word decisions register on the edge of the bit's last valid sample; no backpressure, invalid samples are skipped.
module bask_demod #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int THRESHOLD       = 512
) (
  input  logic         clk,
  input  logic         reset,
  bask_demod_if.slave  bus
);
  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam int ACC_W = 8 + CNT_W;
  localparam logic [ACC_W:0]   THR      = (ACC_W + 1)'(THRESHOLD);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLES_PER_BIT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;

  logic [ACC_W-1:0] sum;
  logic             decision;

  assign sum      = acc_q + {{(ACC_W-8){1'b0}}, bus.sample_in};
  assign decision = ({1'b0, sum} >= THR);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (bus.start) begin
      // Sync always wins: discards any partial word, including a word-completing sample.
      state_d = RUN;
      acc_d   = '0;
      scnt_d  = '0;
      bcnt_d  = '0;
      shreg_d = '0;
    end else if (state_q == IDLE) begin
      acc_d  = '0;
      scnt_d = '0;
      bcnt_d = '0;
    end else if (bus.sample_valid) begin
      if (scnt_q == LAST_SMP) begin
        shreg_d     = {shreg_q[6:0], decision};
        bit_out_d   = decision;
        bit_valid_d = 1'b1;
        acc_d       = '0;
        scnt_d      = '0;
        bcnt_d      = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
          data_out_d   = {shreg_q[6:0], decision};
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end else begin
        acc_d  = sum;
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
endmodule

// File: tb/tb_bask_demod.sv
// Scoreboard bench for bask_demod: expected bits/words come from per-bit sample sums of the generated stream.
module tb_bask_demod;
  logic clk;
  logic reset;
  bask_demod_if bif ();

  bask_demod #(.SAMPLES_PER_BIT(16), .THRESHOLD(512)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  typedef struct {
    logic [7:0] w;
    int         lat;
  } wexp_t;

  bit    exp_bits[$];
  wexp_t exp_words[$];
  int    smp[128];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    start_edge = 0;
  logic [7:0] exp_last = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT output event is matched against the head of the expectation queues.
  always @(negedge clk) begin
    if (reset) begin
      if (bif.bit_valid) begin
        if (exp_bits.size() == 0) chk("unexpected_bit_valid", 1, 0);
        else chk("bit_out", bif.bit_out, exp_bits.pop_front());
      end
      if (bif.data_valid) begin
        if (exp_words.size() == 0) chk("unexpected_data_valid", 1, 0);
        else begin
          wexp_t e;
          e = exp_words.pop_front();
          chk("data_out", bif.data_out, e.w);
          chk("word_latency", cyc - start_edge, e.lat);
          chk("busy_falls_with_data_valid", bif.busy, 0);
        end
      end
    end
  end

  task automatic cyc_drive(input logic st, input logic vld, input logic [7:0] d);
    bif.start        = st;
    bif.sample_valid = vld;
    bif.sample_in    = d;
    if (st) start_edge = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  // Valid sample presented with start is deliberately large: it must not be integrated.
  task automatic do_start();
    cyc_drive(1'b1, 1'b1, 8'd255);
  endtask

  task automatic gen(input logic [7:0] w, input int mode);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 16; k++) begin
        int idx;
        idx = b * 16 + k;
        case (mode)
          0: smp[idx] = w[7-b] ? int'($urandom_range(192, 64)) : 0;
          1: smp[idx] = 255;
          2: smp[idx] = 0;
          3: smp[idx] = int'($urandom_range(63, 0));
          4: smp[idx] = (w[7-b] || k != 15) ? 32 : 31;
          default: smp[idx] = 0;
        endcase
      end
    end
  endtask

  function automatic bit model_bit(input int b);
    int s;
    s = 0;
    for (int k = 0; k < 16; k++) s += smp[b * 16 + k];
    return (s >= 512);
  endfunction

  task automatic feed(input int nsamp, input bit gap, input bit start_last);
    int done;
    logic [7:0] w;
    done = start_last ? (nsamp - 1) / 16 : nsamp / 16;
    w = 8'h00;
    for (int b = 0; b < done; b++) begin
      exp_bits.push_back(model_bit(b));
      w = {w[6:0], model_bit(b)};
    end
    if (done == 8) begin
      exp_words.push_back('{w: w, lat: gap ? 256 : 128});
      exp_last = w;
    end
    for (int i = 0; i < nsamp; i++) begin
      if (gap) cyc_drive(1'b0, 1'b0, 8'd255);
      cyc_drive(start_last && (i == nsamp - 1), 1'b1, 8'(smp[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
  endtask

  task automatic word(input logic [7:0] w, input int mode, input bit gap);
    gen(w, mode);
    do_start();
    feed(128, gap, 1'b0);
    idle(4);
    chk("data_out_hold", bif.data_out, exp_last);
    chk("idle_after_word", bif.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bif.start = 1'b0;
    bif.sample_valid = 1'b0;
    bif.sample_in = 8'h00;
    #12;
    chk("reset_busy", bif.busy, 0);
    chk("reset_data_out", bif.data_out, 0);
    chk("reset_bit_out", bif.bit_out, 0);
    chk("reset_data_valid", bif.data_valid, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    chk("no_start_no_busy", bif.busy, 0);

    word(8'h89, 0, 1'b0);
    word(8'h00, 2, 1'b0);
    word(8'h00, 1, 1'b0);
    word(8'h6B, 4, 1'b0);
    word(8'h94, 4, 1'b0);
    word(8'hA5, 0, 1'b1);

    // Resync after three bits, then a full word.
    gen(8'hF0, 1);
    do_start();
    feed(48, 1'b0, 1'b0);
    gen(8'h3C, 0);
    do_start();
    chk("busy_after_resync", bif.busy, 1);
    feed(128, 1'b0, 1'b0);
    idle(4);
    chk("data_out_resync", bif.data_out, 8'h3C);

    // Start on the word-completing sample: that word is dropped, next one proceeds.
    gen(8'hC3, 0);
    do_start();
    feed(128, 1'b0, 1'b1);
    chk("busy_after_start_on_last", bif.busy, 1);
    gen(8'h71, 0);
    feed(128, 1'b0, 1'b0);
    idle(4);
    chk("data_out_after_start_on_last", bif.data_out, 8'h71);

    // Asynchronous reset mid-word.
    gen(8'hFF, 1);
    do_start();
    feed(40, 1'b0, 1'b0);
    chk("bit_out_before_reset", bif.bit_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_busy", bif.busy, 0);
    chk("async_reset_bit_out", bif.bit_out, 0);
    chk("async_reset_data_out", bif.data_out, 0);
    chk("async_reset_bit_valid", bif.bit_valid, 0);
    exp_last = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    chk("idle_after_reset", bif.busy, 0);
    word(8'h5A, 0, 1'b0);

    for (int r = 0; r < 10; r++)
      word(8'($urandom), int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));

    idle(8);
    chk("bits_drained", exp_bits.size(), 0);
    chk("words_drained", exp_words.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bask_demod.md
# bask_demod

Binary ASK receiver for the FPGA modulation suite: the receive-side counterpart of the BASK transmitter (PISO + carrier mux). Takes the 8-bit modulated sample stream, integrates sample energy over each bit period, slices each bit against a threshold, and reassembles MSB-first serial bits into an 8-bit parallel word. Sits between the sample source (transmitter `mux_out` in loopback, or ADC front end) and the byte consumer.

## Interface

- `SAMPLES_PER_BIT`, 16, samples integrated per bit; power of two, ≥2.
- `THRESHOLD`, 512, decision level; bit = 1 when bit-period sum ≥ `THRESHOLD`.
- `clk` input 1: single system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `sample_in` input 8: unsigned modulated sample; 0 during a "0" bit, carrier samples during a "1" bit.
- `sample_valid` input 1: qualifies `sample_in`; samples with `sample_valid`=0 are ignored.
- `start` input 1: frame sync; next valid sample is sample 0 of bit 7 (MSB).
- `busy` output 1: high while a word is being received.
- `bit_out` output 1: most recently decided bit.
- `bit_valid` output 1: one-cycle pulse when `bit_out` updates.
- `data_out` output 8: last completed word, MSB received first.
- `data_valid` output 1: one-cycle pulse when `data_out` updates.

## Operation

- Accumulator width ACC_W = 8 + log2(`SAMPLES_PER_BIT`) (12 at default); cannot overflow (max 16·255 = 4080).
- FSM states: IDLE, RUN.
  - IDLE: `busy`=0, counters and accumulator held at 0. `start`=1 → RUN.
  - RUN: `busy`=1. Each cycle with `sample_valid`=1: acc += `sample_in`, sample count++.
  - On the valid sample that completes the bit (count = `SAMPLES_PER_BIT`−1): decision = (acc + `sample_in`) ≥ `THRESHOLD`; shift decision into shift register LSB; `bit_out` ← decision; `bit_valid` pulses; acc and sample count clear; bit count++.
  - On completion of bit count 7: `data_out` ← {shreg[6:0], decision}; `data_valid` pulses; → IDLE.
- `start` asserted while in RUN: abort current word (partial bits discarded, no `data_valid`), clear counters/accumulator, restart at bit 7. Same cycle as a word-completing sample: `start` wins; no `data_valid`, no `data_out` update, new word begins.
- `sample_valid` on the same cycle as `start`: that sample is not accumulated; sample 0 is the next valid sample.
- `data_out` holds its value until the next completed word.

## Timing

- Reset (`reset`=0, asynchronous): state IDLE, `busy`=0, `bit_out`=0, `bit_valid`=0, `data_out`=8'h00, `data_valid`=0, accumulator/counters/shift register 0. Deassertion is synchronous to `clk`.
- `start` sampled at edge N → `busy`=1 after edge N.
- Bit latency: `bit_valid`/`bit_out` registered on the same edge as the bit's last valid sample (visible the cycle after it is presented).
- Word latency: `data_valid` high for exactly one cycle, on the edge capturing the 8th bit's last sample; `busy` falls on that same edge.
- Minimum word time: 8·`SAMPLES_PER_BIT` valid samples (128 cycles at default, back-to-back valid).
- Reset mid-word: all progress lost; no `data_valid`; receiver waits for fresh `start`.

## Test plan

- Loopback word 8'b1000_1001: start, then 8 bits × 16 samples (1 → carrier samples averaging 128, 0 → 0) → eight `bit_valid` pulses with bits 1,0,0,0,1,0,0,1; `data_out`=8'h89, one-cycle `data_valid` after sample 128; `busy` falls on that edge.
- Extremes: all-zero stream → 8'h00; constant 255 stream → 8'hFF; `data_out` unchanged between words.
- Threshold boundary: bit with 16 samples of 32 (sum 512) → bit 1; 15×32 + 31 (sum 511) → bit 0.
- Gapped input: `sample_valid` toggling 1/0 every cycle with word 8'hA5 → 8'hA5, `data_valid` after 256 cycles; invalid samples of 255 not accumulated.
- Resync: `start` re-asserted after 3 bits, then full word 8'h3C → only one `data_valid`, `data_out`=8'h3C; `start` on word-completing sample → no `data_valid`.
- Reset mid-word after 40 samples → all outputs at reset values immediately (asynchronous), `busy`=0; subsequent start + 8'h5A → 8'h5A.
